out_port_sched: RTL and testbench

- Output-port scheduler for one cardinal-router output.
- Shares the output register among 4 input requesters: N, E, S, W or local, mapped to indices 0-3.
- Uses round-robin arbitration (rr_arb4) for the packet head. It then locks the grant to the winner until that packet's last flit transfers.
- Drives a 1-entry output register with valid/ready toward the link or the downstream buffer.

---
 rtl/out_port_sched_pkg.sv | 18 +
 rtl/out_port_sched_rr_arb4.sv | 38 +++
 rtl/out_port_sched.sv | 114 +++++++++++
 tb/tb_out_port_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_sched_pkg.sv
// Shared router definitions: default flit width, requester indices and the
// output-port lock FSM states.
package out_port_sched_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned NREQ_DEF   = 4;

  localparam logic [1:0] IDX_N = 2'd0;
  localparam logic [1:0] IDX_E = 2'd1;
  localparam logic [1:0] IDX_S = 2'd2;
  localparam logic [1:0] IDX_W = 2'd3;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } sched_state_t;

endpackage

// File: rtl/out_port_sched_rr_arb4.sv
// 4-way round-robin arbiter; the priority pointer moves to the slot after
// the winner only on a cycle where en is high and something is granted.
module rr_arb4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       en,
  output logic [3:0] gnt
);

  logic [1:0] r_ptr;
  logic [1:0] w_win;
  logic       w_found;

  always_comb begin
    gnt     = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      logic [1:0] w_idx;
      w_idx = r_ptr + 2'(i);
      if (en && !w_found && req[w_idx]) begin
        w_found    = 1'b1;
        w_win      = w_idx;
        gnt[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_win + 2'd1;
    end
  end

endmodule

// File: rtl/out_port_sched.sv
// Output-port scheduler: round-robin head arbitration, per-packet grant lock
// and a 1-entry valid/ready output register.
module out_port_sched
  import out_port_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREQ   = NREQ_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        in_valid,
  input  logic [NREQ*DATA_W-1:0] in_data,
  input  logic [NREQ-1:0]        in_last,
  output logic [NREQ-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   lock_active,
  output logic [1:0]             lock_owner
);

  sched_state_t      r_state;
  logic [1:0]        r_owner;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;

  logic              w_load;
  logic              w_arb_en;
  logic [3:0]        w_gnt;
  logic [NREQ-1:0]   w_in_ready;
  logic              w_xfer;
  logic [1:0]        w_sel;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_last;

  assign w_load   = !r_out_valid || out_ready;
  assign w_arb_en = reset_n && (r_state == ST_ARB) && w_load;

  rr_arb4 u_arb (
    .clk (clk),
    .rst (~reset_n),
    .req (in_valid),
    .en  (w_arb_en),
    .gnt (w_gnt)
  );

  // Grants are suppressed while reset is asserted so nothing is accepted
  // on a cycle whose register update will be discarded.
  always_comb begin
    w_in_ready = '0;
    if (reset_n) begin
      if (r_state == ST_ARB) begin
        w_in_ready = w_gnt;
      end else if (w_load && in_valid[r_owner]) begin
        w_in_ready[r_owner] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_in_ready[i]) w_sel = 2'(i);
    end
  end

  assign w_xfer     = |(in_valid & w_in_ready);
  assign w_sel_data = in_data[w_sel*DATA_W +: DATA_W];
  assign w_sel_last = in_last[w_sel];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_ARB;
      r_owner <= IDX_N;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_xfer && !w_sel_last) begin
            r_state <= ST_LOCK;
            r_owner <= w_sel;
          end
        end
        ST_LOCK: begin
          if (w_xfer && w_sel_last) r_state <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign lock_active = (r_state == ST_LOCK);
  assign lock_owner  = r_owner;

endmodule

// File: tb/tb_out_port_sched.sv
// Directed bench for out_port_sched: reset, single request, fairness,
// packet lock, backpressure and reset during a locked packet.
module tb_out_port_sched;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_last;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          lock_active;
  logic [1:0]    lock_owner;

  int checks = 0;
  int failures = 0;

  out_port_sched #(.DATA_W(DW), .NREQ(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .lock_active (lock_active),
    .lock_owner  (lock_owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    in_valid[i]        = v;
    in_data[i*DW +: DW] = d;
    in_last[i]         = l;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic idle_drain();
    in_valid = '0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 64'h50 + 64'(i), 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 64'h0) begin
        failures++; $display("FAIL reset_out got_valid=%b got_data=%h exp=0/0", out_valid, out_data);
      end
    end
    checks++;
    if (lock_active !== 1'b0 || lock_owner !== 2'd0) begin
      failures++; $display("FAIL reset_lock got=%b/%0d exp=0/0", lock_active, lock_owner);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h50) begin
      failures++; $display("FAIL reset_first_flit got=%b/%h exp=1/50", out_valid, out_data);
    end
    idle_drain();
  endtask

  task automatic test_single();
    do_reset();
    in_valid = '0;
    set_req(2, 1'b1, 64'hA5, 1'b1);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++; $display("FAIL single_ready got=%b exp=0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hA5 || lock_active !== 1'b0) begin
      failures++; $display("FAIL single_out got=%b/%h/%b exp=1/a5/0", out_valid, out_data, lock_active);
    end
    idle_drain();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL single_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 64'h100 + 64'(i), 1'b1);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (in_ready !== (4'b0001 << (k % 4))) begin
        failures++; $display("FAIL fair_grant%0d got=%b exp=%b", k, in_ready, 4'b0001 << (k % 4));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'h100 + 64'(k % 4)) begin
        failures++; $display("FAIL fair_out%0d got=%b/%h exp=1/%h", k, out_valid, out_data, 64'h100 + 64'(k % 4));
      end
    end
    idle_drain();
  endtask

  task automatic test_lock();
    logic [DW-1:0] exp_d [6];
    logic [3:0]    exp_r [6];
    logic          exp_l [6];
    exp_d = '{64'h11, 64'h12, 64'h13, 64'hA2, 64'hA3, 64'hA0};
    exp_r = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_l = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    out_ready = 1'b1;
    // one grant to requester 0 moves the pointer to 1
    in_valid = '0;
    set_req(0, 1'b1, 64'hA0, 1'b1);
    tick();
    set_req(2, 1'b1, 64'hA2, 1'b1);
    set_req(3, 1'b1, 64'hA3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) set_req(1, 1'b1, 64'h11 + 64'(k), (k == 2));
      else       set_req(1, 1'b0, 64'h0, 1'b1);
      #1;
      checks++;
      if (in_ready !== exp_r[k]) begin
        failures++; $display("FAIL lock_ready%0d got=%b exp=%b", k, in_ready, exp_r[k]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin
        failures++; $display("FAIL lock_out%0d got=%b/%h exp=1/%h", k, out_valid, out_data, exp_d[k]);
      end
      checks++;
      if (lock_active !== exp_l[k] || (exp_l[k] && lock_owner !== 2'd1)) begin
        failures++; $display("FAIL lock_state%0d got=%b/%0d exp=%b/1", k, lock_active, lock_owner, exp_l[k]);
      end
    end
    idle_drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    in_valid = '0;
    set_req(0, 1'b1, 64'hB0, 1'b1);
    tick();
    out_ready = 1'b0;
    set_req(0, 1'b0, 64'h0, 1'b1);
    set_req(1, 1'b1, 64'hB1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_ready%0d got=%b exp=0000", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hB0 || out_last !== 1'b1) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/b0/1", c, out_valid, out_data, out_last);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready);
    end
    set_req(1, 1'b1, 64'hB1, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hB1 || out_last !== 1'b1) begin
      failures++; $display("FAIL bp_reload got=%b/%h/%b exp=1/b1/1", out_valid, out_data, out_last);
    end
    idle_drain();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    out_ready = 1'b1;
    in_valid = '0;
    set_req(3, 1'b1, 64'hC1, 1'b0);
    tick();
    set_req(3, 1'b1, 64'hC2, 1'b0);
    tick();
    checks++;
    if (lock_active !== 1'b1 || lock_owner !== 2'd3 || out_data !== 64'hC2) begin
      failures++; $display("FAIL midlock_pre got=%b/%0d/%h exp=1/3/c2", lock_active, lock_owner, out_data);
    end
    reset_n = 1'b0;
    set_req(3, 1'b1, 64'hC3, 1'b0);
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++; $display("FAIL midlock_rst_ready got=%b exp=0000", in_ready);
    end
    tick();
    checks++;
    if (lock_active !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midlock_rst got=%b/%b exp=0/0", lock_active, out_valid);
    end
    reset_n = 1'b1;
    set_req(0, 1'b1, 64'hD0, 1'b1);
    set_req(3, 1'b1, 64'hD3, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++; $display("FAIL midlock_regrant got=%b exp=0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hD0 || lock_active !== 1'b0) begin
      failures++; $display("FAIL midlock_out got=%b/%h/%b exp=1/d0/0", out_valid, out_data, lock_active);
    end
    idle_drain();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_backpressure();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
